// File: rtl/execute_stage.sv
// execute_stage: RV32I EX pipeline stage.
//   Forwards rs1/rs2 from EX/MEM (non-load results only) or MEM/WB, runs the
//   ALU, resolves branches/jumps combinationally and registers the result into
//   the EX/MEM pipeline register.
// Ports:
//   clk, rst                 pipeline clock, async active-high reset
//   ID_EX_*                  operands and controls from the ID/EX register
//   kill                     squash the instruction currently in EX
//   MEM_WB_RD/_regwrite_en/_result   write-back forwarding source
//   EX_MEM_*                 registered results toward the memory stage
//   branch_taken/_target     combinational redirect to fetch / hazard logic
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ID_EX_RD1,
   input  logic [XLEN-1:0] ID_EX_RD2,
   input  logic [XLEN-1:0] ID_EX_IMM,
   input  logic [XLEN-1:0] ID_EX_PC,
   input  logic [4:0]      ID_EX_RS1,
   input  logic [4:0]      ID_EX_RS2,
   input  logic [4:0]      ID_EX_RD,
   input  logic [3:0]      ID_EX_alu_ctrl,
   input  logic            ID_EX_alusrc,
   input  logic            ID_EX_memwrite_en,
   input  logic            ID_EX_regwrite_en,
   input  logic            ID_EX_wb_sel,
   input  logic            ID_EX_branch,
   input  logic [2:0]      ID_EX_funct3,
   input  logic            ID_EX_jump,
   input  logic            ID_EX_jalr,
   input  logic            kill,
   input  logic [4:0]      MEM_WB_RD,
   input  logic            MEM_WB_regwrite_en,
   input  logic [XLEN-1:0] MEM_WB_result,
   output logic [XLEN-1:0] EX_MEM_ALU_OUT,
   output logic [XLEN-1:0] EX_MEM_writedata,
   output logic [4:0]      EX_MEM_RD,
   output logic            EX_MEM_memwrite_en,
   output logic            EX_MEM_regwrite_en,
   output logic            EX_MEM_wb_sel,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target
);

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] ex_result;
   logic [4:0]      shamt;
   logic            cond;
   logic            fwd_ex_a;
   logic            fwd_ex_b;
   logic            fwd_wb_a;
   logic            fwd_wb_b;
   logic            ex_fwd_ok;

   // A load sitting in EX/MEM holds an address, not the loaded data, so it is
   // never a forwarding source; upstream hazard logic stalls that case.
   assign ex_fwd_ok = EX_MEM_regwrite_en && !EX_MEM_wb_sel && (EX_MEM_RD != 5'd0);
   assign fwd_ex_a  = ex_fwd_ok && (EX_MEM_RD == ID_EX_RS1);
   assign fwd_ex_b  = ex_fwd_ok && (EX_MEM_RD == ID_EX_RS2);
   assign fwd_wb_a  = MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_EX_RS1);
   assign fwd_wb_b  = MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_EX_RS2);

   always_comb begin
      op_a = ID_EX_RD1;
      if (fwd_ex_a)
         op_a = EX_MEM_ALU_OUT;
      else if (fwd_wb_a)
         op_a = MEM_WB_result;
   end

   always_comb begin
      rs2_val = ID_EX_RD2;
      if (fwd_ex_b)
         rs2_val = EX_MEM_ALU_OUT;
      else if (fwd_wb_b)
         rs2_val = MEM_WB_result;
   end

   assign op_b  = ID_EX_alusrc ? ID_EX_IMM : rs2_val;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_result = '0;
      case (ID_EX_alu_ctrl)
         ALU_ADD:   alu_result = op_a + op_b;
         ALU_SUB:   alu_result = op_a - op_b;
         ALU_AND:   alu_result = op_a & op_b;
         ALU_OR:    alu_result = op_a | op_b;
         ALU_XOR:   alu_result = op_a ^ op_b;
         ALU_SLL:   alu_result = op_a << shamt;
         ALU_SRL:   alu_result = op_a >> shamt;
         ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
         ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_PASSB: alu_result = op_b;
         default:   alu_result = '0;
      endcase
   end

   // Branch compares always use the forwarded rs2 value, never the immediate.
   always_comb begin
      cond = 1'b0;
      case (ID_EX_funct3)
         3'b000:  cond = (op_a == rs2_val);
         3'b001:  cond = (op_a != rs2_val);
         3'b100:  cond = ($signed(op_a) <  $signed(rs2_val));
         3'b101:  cond = ($signed(op_a) >= $signed(rs2_val));
         3'b110:  cond = (op_a <  rs2_val);
         3'b111:  cond = (op_a >= rs2_val);
         default: cond = 1'b0;
      endcase
   end

   assign branch_taken = !rst && !kill &&
                         (ID_EX_jump || ID_EX_jalr || (ID_EX_branch && cond));

   always_comb begin
      branch_target = ID_EX_PC + ID_EX_IMM;
      if (ID_EX_jalr)
         branch_target = (op_a + ID_EX_IMM) & ~{{(XLEN-1){1'b0}}, 1'b1};
   end

   // Jumps write the link address instead of the ALU result.
   assign ex_result = (ID_EX_jump || ID_EX_jalr) ? (ID_EX_PC + 32'd4) : alu_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         EX_MEM_ALU_OUT     <= '0;
         EX_MEM_writedata   <= '0;
         EX_MEM_RD          <= '0;
         EX_MEM_memwrite_en <= 1'b0;
         EX_MEM_regwrite_en <= 1'b0;
         EX_MEM_wb_sel      <= 1'b0;
      end else if (kill) begin
         EX_MEM_ALU_OUT     <= '0;
         EX_MEM_writedata   <= '0;
         EX_MEM_RD          <= '0;
         EX_MEM_memwrite_en <= 1'b0;
         EX_MEM_regwrite_en <= 1'b0;
         EX_MEM_wb_sel      <= 1'b0;
      end else begin
         EX_MEM_ALU_OUT     <= ex_result;
         EX_MEM_writedata   <= rs2_val;
         EX_MEM_RD          <= ID_EX_RD;
         EX_MEM_memwrite_en <= ID_EX_memwrite_en;
         EX_MEM_regwrite_en <= ID_EX_regwrite_en;
         EX_MEM_wb_sel      <= ID_EX_wb_sel;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a
// behavioural model of the EX stage kept in the bench.
module tb_execute_stage;

   logic        clk;
   logic        rst;
   logic [31:0] ID_EX_RD1, ID_EX_RD2, ID_EX_IMM, ID_EX_PC;
   logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
   logic [3:0]  ID_EX_alu_ctrl;
   logic        ID_EX_alusrc, ID_EX_memwrite_en, ID_EX_regwrite_en, ID_EX_wb_sel;
   logic        ID_EX_branch, ID_EX_jump, ID_EX_jalr;
   logic [2:0]  ID_EX_funct3;
   logic        kill;
   logic [4:0]  MEM_WB_RD;
   logic        MEM_WB_regwrite_en;
   logic [31:0] MEM_WB_result;
   logic [31:0] EX_MEM_ALU_OUT, EX_MEM_writedata;
   logic [4:0]  EX_MEM_RD;
   logic        EX_MEM_memwrite_en, EX_MEM_regwrite_en, EX_MEM_wb_sel;
   logic        branch_taken;
   logic [31:0] branch_target;

   int n_vec = 0;
   int n_err = 0;

   // model of the EX/MEM register contents
   logic [31:0] m_alu, m_wd;
   logic [4:0]  m_rd;
   logic        m_mw, m_rw, m_wb;
   // model next state and combinational predictions
   logic [31:0] x_alu, x_wd, x_target;
   logic [4:0]  x_rd;
   logic        x_mw, x_rw, x_wb, x_taken;

   execute_stage dut (
      .clk(clk), .rst(rst),
      .ID_EX_RD1(ID_EX_RD1), .ID_EX_RD2(ID_EX_RD2), .ID_EX_IMM(ID_EX_IMM), .ID_EX_PC(ID_EX_PC),
      .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
      .ID_EX_alu_ctrl(ID_EX_alu_ctrl), .ID_EX_alusrc(ID_EX_alusrc),
      .ID_EX_memwrite_en(ID_EX_memwrite_en), .ID_EX_regwrite_en(ID_EX_regwrite_en),
      .ID_EX_wb_sel(ID_EX_wb_sel), .ID_EX_branch(ID_EX_branch), .ID_EX_funct3(ID_EX_funct3),
      .ID_EX_jump(ID_EX_jump), .ID_EX_jalr(ID_EX_jalr), .kill(kill),
      .MEM_WB_RD(MEM_WB_RD), .MEM_WB_regwrite_en(MEM_WB_regwrite_en), .MEM_WB_result(MEM_WB_result),
      .EX_MEM_ALU_OUT(EX_MEM_ALU_OUT), .EX_MEM_writedata(EX_MEM_writedata), .EX_MEM_RD(EX_MEM_RD),
      .EX_MEM_memwrite_en(EX_MEM_memwrite_en), .EX_MEM_regwrite_en(EX_MEM_regwrite_en),
      .EX_MEM_wb_sel(EX_MEM_wb_sel), .branch_taken(branch_taken), .branch_target(branch_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [31:0] source_value(input logic [4:0] idx, input logic [31:0] rf);
      if (m_rw && !m_wb && m_rd != 0 && m_rd == idx) return m_alu;
      if (MEM_WB_regwrite_en && MEM_WB_RD != 0 && MEM_WB_RD == idx) return MEM_WB_result;
      return rf;
   endfunction

   function automatic void model_eval();
      logic [31:0] a, r2, b, res;
      int sh;
      logic c;
      a  = source_value(ID_EX_RS1, ID_EX_RD1);
      r2 = source_value(ID_EX_RS2, ID_EX_RD2);
      b  = ID_EX_alusrc ? ID_EX_IMM : r2;
      sh = int'(b % 32);
      case (ID_EX_alu_ctrl)
         4'd0:    res = a + b;
         4'd1:    res = a - b;
         4'd2:    res = a & b;
         4'd3:    res = a | b;
         4'd4:    res = a ^ b;
         4'd5:    res = a << sh;
         4'd6:    res = a >> sh;
         4'd7:    res = 32'($signed(a) >>> sh);
         4'd8:    res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9:    res = (a < b) ? 32'd1 : 32'd0;
         4'd10:   res = b;
         default: res = 32'd0;
      endcase
      case (ID_EX_funct3)
         3'b000:  c = (a == r2);
         3'b001:  c = (a != r2);
         3'b100:  c = (int'(a) < int'(r2));
         3'b101:  c = !(int'(a) < int'(r2));
         3'b110:  c = (a < r2);
         3'b111:  c = !(a < r2);
         default: c = 1'b0;
      endcase
      x_taken  = !rst && !kill && (ID_EX_jump || ID_EX_jalr || (ID_EX_branch && c));
      x_target = ID_EX_jalr ? ((a + ID_EX_IMM) & 32'hFFFF_FFFE) : (ID_EX_PC + ID_EX_IMM);
      if (kill || rst) begin
         x_alu = 0; x_wd = 0; x_rd = 0; x_mw = 0; x_rw = 0; x_wb = 0;
      end else begin
         x_alu = (ID_EX_jump || ID_EX_jalr) ? ID_EX_PC + 32'd4 : res;
         x_wd  = r2;
         x_rd  = ID_EX_RD;
         x_mw  = ID_EX_memwrite_en;
         x_rw  = ID_EX_regwrite_en;
         x_wb  = ID_EX_wb_sel;
      end
   endfunction

   task automatic clear_inputs();
      ID_EX_RD1 = 0; ID_EX_RD2 = 0; ID_EX_IMM = 0; ID_EX_PC = 0;
      ID_EX_RS1 = 0; ID_EX_RS2 = 0; ID_EX_RD = 0; ID_EX_alu_ctrl = 0;
      ID_EX_alusrc = 0; ID_EX_memwrite_en = 0; ID_EX_regwrite_en = 0; ID_EX_wb_sel = 0;
      ID_EX_branch = 0; ID_EX_funct3 = 3'b010; ID_EX_jump = 0; ID_EX_jalr = 0;
      kill = 0; MEM_WB_RD = 0; MEM_WB_regwrite_en = 0; MEM_WB_result = 0;
   endtask

   task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
      clear_inputs();
      ID_EX_alu_ctrl = op; ID_EX_RD1 = a; ID_EX_RD2 = b; ID_EX_RD = rd;
      ID_EX_regwrite_en = 1'b1;
   endtask

   // Evaluate the model on the current inputs, clock once, commit model state.
   task automatic advance();
      model_eval();
      @(posedge clk);
      #1;
      m_alu = x_alu; m_wd = x_wd; m_rd = x_rd; m_mw = x_mw; m_rw = x_rw; m_wb = x_wb;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      ID_EX_RD1 = 32'h1234; ID_EX_RD = 5'd9; ID_EX_regwrite_en = 1; ID_EX_jump = 1;
      ID_EX_memwrite_en = 1; ID_EX_wb_sel = 1;
      @(posedge clk); #1;
      m_alu = 0; m_wd = 0; m_rd = 0; m_mw = 0; m_rw = 0; m_wb = 0;
      n_vec++;
      if ({EX_MEM_ALU_OUT, EX_MEM_writedata, EX_MEM_RD, EX_MEM_memwrite_en,
           EX_MEM_regwrite_en, EX_MEM_wb_sel} !== '0) begin
         n_err++;
         $display("FAIL reset_regs got alu=%h wd=%h rd=%0d mw=%b rw=%b wb=%b want all 0",
                  EX_MEM_ALU_OUT, EX_MEM_writedata, EX_MEM_RD, EX_MEM_memwrite_en,
                  EX_MEM_regwrite_en, EX_MEM_wb_sel);
      end
      n_vec++;
      if (branch_taken !== 1'b0) begin
         n_err++; $display("FAIL reset_taken got %b want 0", branch_taken);
      end
      rst = 1'b0;
      set_alu(4'd0, 32'd5, 32'd7, 5'd3);
      advance();
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'd12 || EX_MEM_RD !== 5'd3 || EX_MEM_regwrite_en !== 1'b1) begin
         n_err++;
         $display("FAIL first_add got alu=%0d rd=%0d rw=%b want alu=12 rd=3 rw=1",
                  EX_MEM_ALU_OUT, EX_MEM_RD, EX_MEM_regwrite_en);
      end
      // asynchronous assertion mid-cycle clears the pipeline register at once
      set_alu(4'd0, 32'd40, 32'd2, 5'd6);
      ID_EX_jump = 1;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'd0 || EX_MEM_RD !== 5'd0 || EX_MEM_regwrite_en !== 1'b0
          || branch_taken !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset got alu=%h rd=%0d rw=%b taken=%b want 0",
                  EX_MEM_ALU_OUT, EX_MEM_RD, EX_MEM_regwrite_en, branch_taken);
      end
      @(posedge clk); #1;
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'd0 || EX_MEM_regwrite_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold got alu=%h rw=%b want 0", EX_MEM_ALU_OUT, EX_MEM_regwrite_en);
      end
      m_alu = 0; m_wd = 0; m_rd = 0; m_mw = 0; m_rw = 0; m_wb = 0;
      rst = 1'b0;
      set_alu(4'd1, 32'd40, 32'd2, 5'd6);
      advance();
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'd38 || EX_MEM_RD !== 5'd6) begin
         n_err++;
         $display("FAIL post_reset got alu=%0d rd=%0d want alu=38 rd=6", EX_MEM_ALU_OUT, EX_MEM_RD);
      end
   endtask

   task automatic test_forwarding();
      logic [31:0] want [3] = '{32'd99, 32'd49, 32'd19};
      for (int k = 0; k < 3; k++) begin
         set_alu(4'd0, 32'd100, 32'd0, (k == 2) ? 5'd0 : 5'd3);
         ID_EX_wb_sel = (k == 1);
         advance();
         set_alu(4'd1, (k == 2) ? 32'd20 : 32'd0, 32'd1, 5'd5);
         ID_EX_RS1 = (k == 2) ? 5'd0 : 5'd3;
         MEM_WB_RD = (k == 2) ? 5'd0 : 5'd3;
         MEM_WB_regwrite_en = 1; MEM_WB_result = 32'd50;
         advance();
         n_vec++;
         if (EX_MEM_ALU_OUT !== want[k]) begin
            n_err++;
            $display("FAIL fwd_case%0d got %0d want %0d", k, EX_MEM_ALU_OUT, want[k]);
         end
      end
   endtask

   task automatic test_store();
      clear_inputs();
      ID_EX_RS1 = 5'd1; ID_EX_RS2 = 5'd4; ID_EX_RD1 = 32'h100; ID_EX_RD2 = 32'h5;
      ID_EX_IMM = 32'd8; ID_EX_alusrc = 1; ID_EX_memwrite_en = 1;
      MEM_WB_RD = 5'd4; MEM_WB_regwrite_en = 1; MEM_WB_result = 32'hDEADBEEF;
      advance();
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'h108 || EX_MEM_writedata !== 32'hDEADBEEF
          || EX_MEM_memwrite_en !== 1'b1) begin
         n_err++;
         $display("FAIL store got addr=%h wd=%h mw=%b want 108 deadbeef 1",
                  EX_MEM_ALU_OUT, EX_MEM_writedata, EX_MEM_memwrite_en);
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0]  ops  [5] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
      logic [31:0] as   [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h77};
      logic [31:0] bs   [5] = '{32'd4, 32'd1, 32'd1, 32'hABCD0000, 32'h3};
      logic [31:0] want [5] = '{32'hF8000000, 32'd1, 32'd0, 32'hABCD0000, 32'd0};
      for (int k = 0; k < 5; k++) begin
         set_alu(ops[k], as[k], bs[k], 5'd2);
         advance();
         n_vec++;
         if (EX_MEM_ALU_OUT !== want[k]) begin
            n_err++;
            $display("FAIL alu_op%0d got %h want %h", ops[k], EX_MEM_ALU_OUT, want[k]);
         end
      end
   endtask

   task automatic test_branches();
      // BEQ taken, backwards offset
      clear_inputs();
      ID_EX_branch = 1; ID_EX_funct3 = 3'b000; ID_EX_RD1 = 32'd9; ID_EX_RD2 = 32'd9;
      ID_EX_PC = 32'h40; ID_EX_IMM = 32'hFFFFFFF0;
      #1;
      n_vec++;
      if (branch_taken !== 1'b1 || branch_target !== 32'h30) begin
         n_err++;
         $display("FAIL beq got taken=%b tgt=%h want 1 00000030", branch_taken, branch_target);
      end
      advance();
      // BGEU 1 vs max unsigned: not taken
      ID_EX_funct3 = 3'b111; ID_EX_RD1 = 32'd1; ID_EX_RD2 = 32'hFFFFFFFF;
      #1;
      n_vec++;
      if (branch_taken !== 1'b0) begin
         n_err++; $display("FAIL bgeu got taken=%b want 0", branch_taken);
      end
      advance();
      // JALR clears bit 0 of the target and links PC+4
      clear_inputs();
      ID_EX_jalr = 1; ID_EX_RD1 = 32'h1001; ID_EX_IMM = 32'd2; ID_EX_PC = 32'h80;
      ID_EX_RD = 5'd1; ID_EX_regwrite_en = 1;
      #1;
      n_vec++;
      if (branch_taken !== 1'b1 || branch_target !== 32'h1002) begin
         n_err++;
         $display("FAIL jalr got taken=%b tgt=%h want 1 00001002", branch_taken, branch_target);
      end
      advance();
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'h84) begin
         n_err++; $display("FAIL jalr_link got %h want 00000084", EX_MEM_ALU_OUT);
      end
   endtask

   task automatic test_kill();
      set_alu(4'd0, 32'd3, 32'd4, 5'd7);
      ID_EX_memwrite_en = 1;
      advance();
      clear_inputs();
      ID_EX_jump = 1; ID_EX_PC = 32'h200; ID_EX_IMM = 32'h40; ID_EX_RD = 5'd1;
      ID_EX_regwrite_en = 1; ID_EX_RD2 = 32'h55; kill = 1;
      #1;
      n_vec++;
      if (branch_taken !== 1'b0) begin
         n_err++; $display("FAIL kill_taken got %b want 0", branch_taken);
      end
      advance();
      n_vec++;
      if (EX_MEM_regwrite_en !== 1'b0 || EX_MEM_RD !== 5'd0 || EX_MEM_ALU_OUT !== 32'd0
          || EX_MEM_writedata !== 32'd0 || EX_MEM_memwrite_en !== 1'b0) begin
         n_err++;
         $display("FAIL kill_bubble got rw=%b rd=%0d alu=%h wd=%h mw=%b want all 0",
                  EX_MEM_regwrite_en, EX_MEM_RD, EX_MEM_ALU_OUT, EX_MEM_writedata,
                  EX_MEM_memwrite_en);
      end
      kill = 0;
      #1;
      n_vec++;
      if (branch_taken !== 1'b1 || branch_target !== 32'h240) begin
         n_err++;
         $display("FAIL jal got taken=%b tgt=%h want 1 00000240", branch_taken, branch_target);
      end
      advance();
      n_vec++;
      if (EX_MEM_ALU_OUT !== 32'h204 || EX_MEM_RD !== 5'd1) begin
         n_err++;
         $display("FAIL jal_link got alu=%h rd=%0d want 00000204 1", EX_MEM_ALU_OUT, EX_MEM_RD);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         ID_EX_RD1 = $urandom; ID_EX_RD2 = $urandom; ID_EX_PC = $urandom & 32'hFFFF_FFFC;
         ID_EX_IMM = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         ID_EX_RS1 = 5'($urandom_range(0, 3)); ID_EX_RS2 = 5'($urandom_range(0, 3));
         ID_EX_RD = 5'($urandom_range(0, 3));
         ID_EX_alu_ctrl = 4'($urandom_range(0, 15));
         ID_EX_alusrc = 1'($urandom); ID_EX_memwrite_en = 1'($urandom);
         ID_EX_regwrite_en = 1'($urandom); ID_EX_wb_sel = 1'($urandom);
         ID_EX_branch = 1'($urandom); ID_EX_funct3 = 3'($urandom);
         ID_EX_jump = ($urandom_range(0, 7) == 0); ID_EX_jalr = ($urandom_range(0, 7) == 0);
         kill = ($urandom_range(0, 7) == 0);
         MEM_WB_RD = 5'($urandom_range(0, 3)); MEM_WB_regwrite_en = 1'($urandom);
         MEM_WB_result = $urandom;
         if ($urandom_range(0, 3) == 0) ID_EX_RD2 = ID_EX_RD1;
         #1;
         model_eval();
         n_vec++;
         if (branch_taken !== x_taken || (x_taken && branch_target !== x_target)) begin
            n_err++;
            $display("FAIL rnd%0d_branch got taken=%b tgt=%h want taken=%b tgt=%h",
                     i, branch_taken, branch_target, x_taken, x_target);
         end
         advance();
         n_vec++;
         if (EX_MEM_ALU_OUT !== m_alu || EX_MEM_writedata !== m_wd || EX_MEM_RD !== m_rd
             || EX_MEM_memwrite_en !== m_mw || EX_MEM_regwrite_en !== m_rw
             || EX_MEM_wb_sel !== m_wb) begin
            n_err++;
            $display("FAIL rnd%0d_regs got alu=%h wd=%h rd=%0d mw=%b rw=%b wb=%b want alu=%h wd=%h rd=%0d mw=%b rw=%b wb=%b",
                     i, EX_MEM_ALU_OUT, EX_MEM_writedata, EX_MEM_RD, EX_MEM_memwrite_en,
                     EX_MEM_regwrite_en, EX_MEM_wb_sel, m_alu, m_wd, m_rd, m_mw, m_rw, m_wb);
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_forwarding();
      test_store();
      test_alu_ops();
      test_branches();
      test_kill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
